// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch widths, opcode constants, fetch FSM states and
// the {instr, pc} entry carried through the prefetch path.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned PC_STEP = 2;

    localparam logic [OP_W-1:0] HALT_OP = 4'b1110;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry prefetch FIFO. Entry 0 is always the head, so the outputs come
// straight from a register; flush wins over push and pop.
module fetch_buf import cpu_pkg::*; #(
    parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
    parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [1:0]         count
);

    logic [INSTR_W-1:0] instr_q [2];
    logic [ADDR_W-1:0]  pc_q    [2];
    logic [1:0]         count_q;
    logic               pop_ok;

    assign pop_ok     = pop && (count_q != 2'd0);
    assign head_instr = instr_q[0];
    assign head_pc    = pc_q[0];
    assign count      = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            count_q    <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        instr_q[0] <= push_instr;
                        pc_q[0]    <= push_pc;
                    end else begin
                        instr_q[1] <= push_instr;
                        pc_q[1]    <= push_pc;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    instr_q[0] <= instr_q[1];
                    pc_q[0]    <= pc_q[1];
                    count_q    <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        instr_q[0] <= push_instr;
                        pc_q[0]    <= push_pc;
                    end else begin
                        instr_q[0] <= instr_q[1];
                        pc_q[0]    <= pc_q[1];
                        instr_q[1] <= push_instr;
                        pc_q[1]    <= push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches into a 2-entry prefetch
// buffer, honours redirects and stops on the HALT opcode.
module fetch_ctrl import cpu_pkg::*; #(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = cpu_pkg::HALT_OP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  Address,
    input  logic [INSTR_W-1:0] Instruction,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [ADDR_W-1:0]  PCOut,
    output logic               Valid,
    input  logic               Ready,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  Target,
    output logic               Halted
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              halted_q;
    logic [1:0]        count;
    logic              deq;
    logic              can_fetch;
    logic              is_halt;

    assign Valid     = (count != 2'd0);
    assign deq       = Valid && Ready;
    assign can_fetch = (state_q == StRun) && !Redirect && ((count != 2'd2) || deq);
    assign is_halt   = (Instruction[INSTR_W-1 -: 4] == HALT_OP);
    assign Address   = pc_q;
    assign Halted    = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else if (Redirect) begin
            state_q  <= StRun;
            pc_q     <= Target & ~ADDR_W'(1);
            halted_q <= 1'b0;
        end else if (can_fetch) begin
            // The HALT word itself is still queued; only the PC stops advancing.
            if (is_halt) begin
                state_q  <= StHalt;
                halted_q <= 1'b1;
            end else begin
                pc_q <= pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    fetch_buf #(
        .INSTR_W(INSTR_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (Redirect),
        .push      (can_fetch),
        .pop       (deq),
        .push_instr(Instruction),
        .push_pc   (pc_q),
        .head_instr(InstrOut),
        .head_pc   (PCOut),
        .count     (count)
    );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 16-bit instruction memory.
- Owns the byte-addressed PC (step 2) and drives the memory Address. The memory returns its Instruction combinationally in the same cycle.
- Captures fetched words into a 2-entry prefetch buffer and hands them to decode over a Valid/Ready handshake.
- Handles branch/jump redirects from later stages and stops fetching on the HALT opcode.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width (byte address)
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value loaded at reset
- HALT_OP, 4'b1110, value of Instruction[15:12] that halts fetch

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Address  out  ADDR_W  address to instruction memory; equals PC register
- Instruction  in  INSTR_W  word from instruction memory for Address (combinational, same cycle)
- InstrOut  out  INSTR_W  instruction at buffer head
- PCOut  out  ADDR_W  address of InstrOut
- Valid  out  1  buffer head holds a valid instruction
- Ready  in  1  decode accepts head this cycle when Valid && Ready
- Redirect  in  1  branch/jump taken; flush and reload PC
- Target  in  ADDR_W  redirect address; bit 0 ignored (forced 0)
- Halted  out  1  fetch stopped on HALT opcode

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, buffer count=0, state=RUN.
  - Valid=0, Halted=0, InstrOut=0, PCOut=0.
  - Address=RESET_PC.
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- States:
  - RUN: fetch enabled.
  - HALT: fetch disabled, PC frozen.
- deq = Valid && Ready.
- can_fetch = (state==RUN) && !Redirect && (count<2 || deq).
- Fetch cycle (can_fetch=1):
  - Push {Instruction, PC} into buffer.
  - If Instruction[15:12]==HALT_OP: PC unchanged, state to HALT.
  - Otherwise PC<=PC+2, modulo 2^ADDR_W (0xFE wraps to 0x00).
- Fetch-to-Valid latency is 1 cycle: a word fetched in cycle N is at the head in cycle N+1.
- Buffer:
  - 2-entry FIFO; InstrOut/PCOut come from the registered head entry.
  - Valid = (count!=0).
  - Push and pop in the same cycle when full: legal, count stays 2.
  - Pop when empty: impossible, since Valid=0.
- Ready=0 with Valid=1: head holds stable; at most 2 entries accumulate, then PC holds.
- Redirect=1 (highest priority, both states):
  - Buffer flushed (count<=0); no push, and any pop that cycle is discarded.
  - PC<={Target[ADDR_W-1:1],1'b0}; state<=RUN; Halted<=0.
  - Next cycle: Address=Target, Valid=0. The cycle after: Valid=1 with the target word.
- HALT state:
  - Halted=1.
  - Buffered entries, including the HALT word, still drain normally.
  - Leaves HALT only via Redirect or reset.
- Reset mid-operation: immediately returns all state to reset values regardless of handshake.
- Halted is registered; it asserts the cycle after the HALT word is fetched.

Decomposition:
- Shared package (cpu_pkg) holds: HALT_OP and other opcode constants, ADDR_W/INSTR_W, PC step constant (2), and a fetch-entry struct {instr, pc}.
- One natural sub-module, fetch_buf: 2-entry FIFO with push/pop/flush and count. The PC/state logic stays in fetch_ctrl.

Test Plan:
- Reset then Ready=1, with memory word 0x012F at 0x00 and 0x012E at 0x02:
  - Cycle 0: Address=0x00, Valid=0.
  - Cycle 1: Valid=1, InstrOut=0x012F, PCOut=0x00, Address=0x02.
  - Cycle 2: InstrOut=0x012E.
- Ready=0 from reset for 4 cycles: count reaches 2, Address holds 0x04, InstrOut stays 0x012F. Then Ready=1: PCOut sequence 0x00, 0x02, 0x04 with no gaps or duplicates.
- Redirect=1, Target=0x1B while Valid=1:
  - Next cycle: Valid=0, Address=0x1A.
  - Following cycle: InstrOut=0x470D, PCOut=0x1A.
- Run to 0x32, which holds 0xEFFF:
  - Halted=1 the next cycle; Address frozen at 0x32.
  - Preceding words drain; 0xEFFF is delivered at PCOut=0x32; afterwards Valid=0.
  - Then Redirect to Target=0x00: Halted=0, fetch resumes from 0x00.
- RESET_PC=0xFE, non-halt word at 0xFE: after one fetch, Address=0x00 (wrap) and PCOut=0xFE.
- Assert rst_n=0 mid-stream with count=2 and Halted=1: Valid, Halted and count clear immediately without waiting for a clock edge; Address=RESET_PC.
